dm_load_unit: RTL
=================

# dm_load_unit

Load-side requester for the 4 KB word-addressed data memory. Accepts one load request at a time from the CPU over a valid/ready handshake and issues a single word read to the memory read port. It then extracts and extends the addressed byte, halfword or word and returns the result over a valid/ready response channel. It sits between the execute/memory stage and the data memory, and is the read counterpart of the byte-lane store path. The byte-lane mapping matches `sb`: offset 0 selects bits [7:0], offset 3 selects bits [31:24].

## Interface
- `DEPTH_LOG2`, default 10, word-index width; memory holds 2^DEPTH_LOG2 words.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit can accept a request.
- `req_op` in 6: MIPS opcode; `lb`=100000, `lh`=100001, `lw`=100011, `lbu`=100100, `lhu`=100101.
- `req_addr` in 32: byte address.
- `mem_re` out 1: memory read strobe.
- `mem_raddr` out DEPTH_LOG2: word index, equal to `addr[DEPTH_LOG2+1:2]`.
- `mem_rdata` in 32: read word, valid in the cycle after `mem_re`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: extended load result.
- `rsp_err` out 1: misaligned address or unsupported opcode.

## Operation
- The FSM has four states: IDLE, READ, CAPT and RESP.
- **IDLE:** `req_ready`=1.
  - On `req_valid`, latch the opcode, the address and an error flag.
  - Error conditions: opcode not in the five listed; `lh`/`lhu` with `addr[0]`=1; `lw` with `addr[1:0]`≠0.
  - On an error, go directly to RESP with `rsp_data`=0 and `rsp_err`=1. `mem_re` is never asserted for that request.
  - Otherwise go to READ.
- **READ:** `mem_re`=1 and `mem_raddr` is driven from the latched address. Next state is CAPT.
- **CAPT:** sample `mem_rdata`, run it through the extractor, register the result into `rsp_data`, set `rsp_err`=0. Next state is RESP.
- **RESP:** `rsp_valid`=1. `rsp_data` and `rsp_err` hold stable until `rsp_ready`=1, then go to IDLE. Back-pressure of any length is allowed.
- **Extraction:**
  - Byte select is `addr[1:0]`; halfword select is `addr[1]` (0 gives [15:0], 1 gives [31:16]).
  - `lb`/`lh` sign-extend; `lbu`/`lhu` zero-extend; `lw` passes the word unchanged.
- `req_ready`=0 in every state except IDLE. Requests are not buffered.
- `rsp_data` and `rsp_err` are held until overwritten by the next response.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `mem_re`=0, `mem_raddr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
- **Normal load:** request accepted at edge N.
  - `mem_re` is high during cycle N+1.
  - `mem_rdata` is sampled at edge N+2.
  - `rsp_valid` is high from cycle N+3.
- **Erroring request:** `rsp_valid` is high from cycle N+1.
- **Throughput:** one normal load per 4 cycles with `rsp_ready` tied high; the next `req_ready` is in cycle N+4.
- **RESP handshake:** if `rsp_ready` and `rsp_valid` coincide, that edge completes the transfer. `req_ready` rises in the following cycle; there is no same-cycle turnaround.
- **Reset mid-operation:** reset in any state forces all reset values at the next edge. The in-flight load is dropped and no response is produced.
- **`mem_rdata` outside CAPT:** ignored.

## Structure
- Shared package `dm_pkg` holds:
  - the opcode localparams `OP_LB`, `OP_LH`, `OP_LW`, `OP_LBU`, `OP_LHU` and `OP_SB`, shared with the store path;
  - the FSM state enum `ld_state_t` (IDLE, READ, CAPT, RESP).
- One sub-module, `load_extract`: purely combinational, inputs op, `addr[1:0]` and word, output the 32-bit extended result. It is reused by any future forwarding path.

## Test plan
Preload memory word index 1 with 0x8A7FC312, `rsp_ready`=1 unless stated.
- `lb` 0x4 → 0x00000012; `lb` 0x5 → 0xFFFFFFC3; `lbu` 0x7 → 0x0000008A. Each has `rsp_valid` 3 cycles after accept and `mem_raddr`=1.
- `lh` 0x6 → 0xFFFF8A7F; `lhu` 0x4 → 0x0000C312; `lw` 0x4 → 0x8A7FC312; `rsp_err`=0 for all.
- Error path:
  - `lw` 0x6 → `rsp_err`=1, `rsp_data`=0, `rsp_valid` 1 cycle after accept, `mem_re` never high.
  - `lh` 0x5 → same error response.
  - op 101011 → same error response.
- Back-pressure: `lw` 0x4 with `rsp_ready`=0 for 5 cycles → `rsp_valid`=1 and `rsp_data`=0x8A7FC312 held all 5 cycles; `req_ready`=0 throughout; `req_valid` during this window is not accepted.
- Reset mid-operation: `rst_n`=0 for one cycle while in READ → next cycle all outputs at reset values, no response ever appears, and a subsequent `lbu` 0x6 → 0x0000007F.
- Back-to-back: 4 consecutive loads with `req_valid` held → accepts spaced exactly 4 cycles, results in order.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store paths: MIPS opcodes,
// load FSM states and the load legality check.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } ld_state_t;

    // Returns 1 when a load cannot be serviced: unknown opcode or misaligned
    // halfword/word access.
    function automatic logic ld_is_err(input logic [5:0] op, input logic [1:0] addr_lo);
        logic err;
        case (op)
            OP_LB, OP_LBU: err = 1'b0;
            OP_LH, OP_LHU: err = addr_lo[0];
            OP_LW:         err = (addr_lo != 2'b00);
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load extractor: selects the addressed byte/halfword/word
// from a memory word and sign- or zero-extends it. Byte lane 0 is [7:0].
module load_extract
    import dm_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the lane, then extend according to the opcode.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0000_0000;

        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase

        if (i_addr_lo[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end

        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h000000, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0000, w_half};
            OP_LW:   o_data = i_word;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// Load requester for the word-addressed data memory. One request at a time:
// IDLE accepts, READ strobes the memory, CAPT extracts the returned word,
// RESP holds the result until the consumer takes it. Illegal requests skip
// the memory and respond with an error straight away.
module dm_load_unit
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_op,
    input  logic [31:0]           req_addr,
    output logic                  mem_re,
    output logic [DEPTH_LOG2-1:0] mem_raddr,
    input  logic [31:0]           mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    ld_state_t             r_state;
    logic [5:0]            r_op;
    logic [1:0]            r_addr_lo;
    logic                  r_req_ready;
    logic                  r_mem_re;
    logic [DEPTH_LOG2-1:0] r_mem_raddr;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_data;
    logic                  r_rsp_err;

    logic                  w_req_err;
    logic [31:0]           w_ext_data;
    logic                  w_unused_addr;

    // Address bits above the memory window do not take part in the access.
    assign w_unused_addr = ^req_addr[31:DEPTH_LOG2+2];

    assign w_req_err = ld_is_err(req_op, req_addr[1:0]);

    load_extract u_extract (
        .i_op      (r_op),
        .i_addr_lo (r_addr_lo),
        .i_word    (mem_rdata),
        .o_data    (w_ext_data)
    );

    // Load FSM with all handshake and memory outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= 6'b000000;
            r_addr_lo   <= 2'b00;
            r_req_ready <= 1'b1;
            r_mem_re    <= 1'b0;
            r_mem_raddr <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_addr_lo   <= req_addr[1:0];
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 32'h0000_0000;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state     <= READ;
                            r_mem_re    <= 1'b1;
                            r_mem_raddr <= req_addr[DEPTH_LOG2+1:2];
                        end
                    end
                end
                READ: begin
                    r_mem_re <= 1'b0;
                    r_state  <= CAPT;
                end
                CAPT: begin
                    r_rsp_data  <= w_ext_data;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_re    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_re    = r_mem_re;
    assign mem_raddr = r_mem_raddr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule
